// File: rtl/cov_accum.sv
// Per-lane covariance integrator: sums 2^LOG2_N product vectors and emits
// their floor-rounded mean as one snapshot per frame on a valid/ready port.
`timescale 1ns/1ps

module cov_accum #(
    parameter int LANES  = 16,
    parameter int DW     = 32,
    parameter int LOG2_N = 10
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  clr,
    input  logic [LANES*DW-1:0]   axis_di0,
    input  logic                  axis_vi0,
    output logic                  axis_ri0,
    output logic [LANES*DW-1:0]   axis_do0,
    output logic                  axis_vo0,
    input  logic                  axis_ro0,
    output logic [15:0]           frame_cnt
);

    localparam int AW = DW + LOG2_N;

    // Handshake: a beat transfers on a rising edge where valid && ready.
    // Valid never waits on ready; once raised, valid and data hold until the
    // beat transfers. Ready here drops only when the closing sample of a frame
    // would overwrite a result the consumer has not yet taken.

    logic [LOG2_N-1:0]      cnt_q,  cnt_d;
    logic signed [AW-1:0]   acc_q  [LANES];
    logic signed [AW-1:0]   acc_d  [LANES];
    logic signed [AW-1:0]   sum    [LANES];
    logic [LANES*DW-1:0]    dout_q, dout_d;
    logic [LANES*DW-1:0]    mean_v;
    logic                   vo_q,   vo_d;
    logic [15:0]            fcnt_q, fcnt_d;
    logic                   last;
    logic                   take;

    assign last     = (cnt_q == {LOG2_N{1'b1}});
    assign axis_ri0 = !(last && vo_q && !axis_ro0);
    assign take     = axis_vi0 && axis_ri0 && !clr;

    assign axis_do0  = dout_q;
    assign axis_vo0  = vo_q;
    assign frame_cnt = fcnt_q;

    // The top DW bits of the widened sum are exactly (sum >>> LOG2_N)
    // truncated to DW, i.e. the floor-rounded mean.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            sum[k] = acc_q[k] + {{LOG2_N{axis_di0[k*DW+DW-1]}}, axis_di0[k*DW +: DW]};
            mean_v[k*DW +: DW] = sum[k][LOG2_N +: DW];
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        dout_d = dout_q;
        vo_d   = vo_q;
        fcnt_d = fcnt_q;

        if (vo_q && axis_ro0) begin
            vo_d = 1'b0;
        end

        if (clr) begin
            cnt_d = '0;
            for (int k = 0; k < LANES; k++) begin
                acc_d[k] = '0;
            end
        end else if (take) begin
            if (last) begin
                cnt_d  = '0;
                for (int k = 0; k < LANES; k++) begin
                    acc_d[k] = '0;
                end
                dout_d = mean_v;
                vo_d   = 1'b1;
                fcnt_d = fcnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q  <= '0;
            dout_q <= '0;
            vo_q   <= 1'b0;
            fcnt_q <= '0;
            for (int k = 0; k < LANES; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            vo_q   <= vo_d;
            fcnt_q <= fcnt_d;
            for (int k = 0; k < LANES; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

endmodule

// File: tb/tb_cov_accum.sv
// Bench for cov_accum with LOG2_N=2: a negedge reference model feeds a result
// queue, and scenario tasks add targeted inline checks.
`timescale 1ns/1ps

module tb_cov_accum;
  localparam int LANES = 16;
  localparam int DW = 32;
  localparam int LOG2_N = 2;
  localparam int VW = LANES * DW;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic clr = 1'b0;
  logic [VW-1:0] axis_di0 = '0;
  logic axis_vi0 = 1'b0;
  logic axis_ri0;
  logic [VW-1:0] axis_do0;
  logic axis_vo0;
  logic axis_ro0 = 1'b1;
  logic [15:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  cov_accum #(.LANES(LANES), .DW(DW), .LOG2_N(LOG2_N)) dut (
    .aclk(aclk), .aresetn(aresetn), .clr(clr),
    .axis_di0(axis_di0), .axis_vi0(axis_vi0), .axis_ri0(axis_ri0),
    .axis_do0(axis_do0), .axis_vo0(axis_vo0), .axis_ro0(axis_ro0),
    .frame_cnt(frame_cnt)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: reference model evaluated at negedge for the coming posedge
  logic [VW-1:0] exp_q[$];
  logic [15:0] exp_fc_q[$];
  longint macc[LANES];
  int mcnt = 0;
  bit mvo = 1'b0;
  logic [15:0] mfc = '0;
  bit held_prev = 1'b0;
  logic [VW-1:0] prev_do = '0;

  always @(negedge aclk) begin
    logic exp_ri;
    logic [VW-1:0] got_v;
    logic [VW-1:0] mean_vec;
    logic [15:0] got_fc;
    longint s;
    longint m;
    logic [DW-1:0] lane;
    if (!aresetn) begin
      for (int k = 0; k < LANES; k++) macc[k] = 0;
      mcnt = 0;
      mvo = 1'b0;
      mfc = '0;
      held_prev = 1'b0;
      exp_q.delete();
      exp_fc_q.delete();
    end else begin
      exp_ri = !(mcnt == (1 << LOG2_N) - 1 && mvo && !axis_ro0);
      checks++;
      if (axis_ri0 !== exp_ri) begin
        failures++;
        $display("FAIL sb_ready: got %b want %b at %0t", axis_ri0, exp_ri, $time);
      end
      checks++;
      if (axis_vo0 !== mvo) begin
        failures++;
        $display("FAIL sb_valid: got %b want %b at %0t", axis_vo0, mvo, $time);
      end
      if (held_prev) begin
        checks++;
        if (axis_do0 !== prev_do) begin
          failures++;
          $display("FAIL sb_hold: data changed while stalled at %0t", $time);
        end
      end
      if (axis_vo0 && axis_ro0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: output beat with empty queue at %0t", $time);
        end else begin
          got_v = exp_q.pop_front();
          got_fc = exp_fc_q.pop_front();
          if (axis_do0 !== got_v || frame_cnt !== got_fc) begin
            failures++;
            $display("FAIL sb_data: got %h fc=%0d want %h fc=%0d", axis_do0, frame_cnt, got_v, got_fc);
          end
        end
      end
      held_prev = axis_vo0 && !axis_ro0;
      prev_do = axis_do0;

      if (mvo && axis_ro0) mvo = 1'b0;
      if (clr) begin
        for (int k = 0; k < LANES; k++) macc[k] = 0;
        mcnt = 0;
      end else if (axis_vi0 && exp_ri) begin
        for (int k = 0; k < LANES; k++) begin
          lane = axis_di0[k*DW +: DW];
          macc[k] = macc[k] + longint'(signed'(lane));
        end
        if (mcnt == (1 << LOG2_N) - 1) begin
          for (int k = 0; k < LANES; k++) begin
            s = macc[k];
            m = s >>> LOG2_N;
            mean_vec[k*DW +: DW] = m[DW-1:0];
            macc[k] = 0;
          end
          mfc = mfc + 16'd1;
          exp_q.push_back(mean_vec);
          exp_fc_q.push_back(mfc);
          mvo = 1'b1;
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
    end
  end

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
    logic [VW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*DW +: DW] = $urandom;
    return r;
  endfunction

  // driver tasks; all start and end at posedge + 1
  task automatic send(input logic [VW-1:0] v, output int waits);
    logic got;
    axis_di0 = v;
    axis_vi0 = 1'b1;
    waits = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge aclk);
      got = axis_ri0;
      @(posedge aclk);
      #1;
      waits++;
    end
    if (!got) begin
      failures++;
      $display("FAIL send_timeout: ready never asserted");
    end
  endtask

  task automatic idle(input int n);
    axis_vi0 = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic do_reset();
    axis_vi0 = 1'b0;
    clr = 1'b0;
    axis_ro0 = 1'b1;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    axis_vi0 = 1'b0;
    aresetn = 1'b0;
    #2;
    checks++;
    if (axis_vo0 !== 1'b0 || axis_do0 !== '0 || frame_cnt !== 16'd0 || axis_ri0 !== 1'b1) begin
      failures++;
      $display("FAIL reset_values: vo=%b do=%h fc=%0d ri=%b", axis_vo0, axis_do0, frame_cnt, axis_ri0);
    end
    do_reset();
    checks++;
    if (axis_vo0 !== 1'b0 || frame_cnt !== 16'd0 || axis_ri0 !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: vo=%b fc=%0d ri=%b", axis_vo0, frame_cnt, axis_ri0);
    end
  endtask

  task automatic test_basic();
    int w;
    do_reset();
    for (int i = 0; i < 4; i++) send(fill(32'h4), w);
    axis_vi0 = 1'b0;
    checks++;
    if (axis_vo0 !== 1'b1 || axis_do0 !== fill(32'h4) || frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL basic_mean: vo=%b do=%h fc=%0d want vo=1 lanes=4 fc=1", axis_vo0, axis_do0, frame_cnt);
    end
    idle(2);
  endtask

  task automatic test_floor();
    int w;
    logic [VW-1:0] v;
    logic [DW-1:0] l0[4];
    l0[0] = 32'hFFFF_FFFD; l0[1] = 32'hFFFF_FFFD; l0[2] = 32'hFFFF_FFFD; l0[3] = 32'hFFFF_FFFE;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = rand_vec();
      v[31:0] = l0[i];
      v[15*DW +: DW] = 32'h7FFF_FFFF;
      send(v, w);
    end
    axis_vi0 = 1'b0;
    checks++;
    if (axis_do0[31:0] !== 32'hFFFF_FFFD) begin
      failures++;
      $display("FAIL floor_lane0: got %h want FFFFFFFD", axis_do0[31:0]);
    end
    checks++;
    if (axis_do0[15*DW +: DW] !== 32'h7FFF_FFFF) begin
      failures++;
      $display("FAIL floor_lane15: got %h want 7FFFFFFF", axis_do0[15*DW +: DW]);
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    int w;
    do_reset();
    axis_ro0 = 1'b0;
    for (int i = 0; i < 7; i++) send(rand_vec(), w);
    axis_di0 = rand_vec();
    axis_vi0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      checks++;
      if (axis_ri0 !== 1'b0 || axis_vo0 !== 1'b1) begin
        failures++;
        $display("FAIL bp_stall: ri=%b vo=%b want ri=0 vo=1", axis_ri0, axis_vo0);
      end
    end
    @(posedge aclk);
    #1;
    axis_ro0 = 1'b1;
    @(posedge aclk);
    #1;
    axis_vi0 = 1'b0;
    checks++;
    if (axis_vo0 !== 1'b1 || frame_cnt !== 16'd2) begin
      failures++;
      $display("FAIL bp_frame2: vo=%b fc=%0d want vo=1 fc=2", axis_vo0, frame_cnt);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    int w;
    logic want_vo;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send(rand_vec(), w);
      want_vo = (i % 4 == 3);
      checks++;
      if (w !== 1 || axis_vo0 !== want_vo) begin
        failures++;
        $display("FAIL b2b_beat%0d: cycles=%0d vo=%b want cycles=1 vo=%b", i, w, axis_vo0, want_vo);
      end
    end
    axis_vi0 = 1'b0;
    checks++;
    if (frame_cnt !== 16'd3) begin
      failures++;
      $display("FAIL b2b_count: fc=%0d want 3", frame_cnt);
    end
    idle(2);
  endtask

  task automatic test_clr();
    int w;
    do_reset();
    for (int i = 0; i < 2; i++) send(fill(32'd100), w);
    axis_vi0 = 1'b0;
    clr = 1'b1;
    @(posedge aclk);
    #1;
    clr = 1'b0;
    for (int i = 0; i < 4; i++) send(fill(32'd8), w);
    axis_vi0 = 1'b0;
    checks++;
    if (axis_vo0 !== 1'b1 || axis_do0 !== fill(32'd8) || frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL clr_restart: vo=%b do=%h fc=%0d want lanes=8 fc=1", axis_vo0, axis_do0, frame_cnt);
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    axis_ro0 = 1'b0;
    for (int i = 0; i < 4; i++) send(fill(32'd1), w);
    for (int i = 0; i < 2; i++) send(fill(32'd12), w);
    axis_vi0 = 1'b0;
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (axis_vo0 !== 1'b0 || axis_do0 !== '0 || frame_cnt !== 16'd0 || axis_ri0 !== 1'b1) begin
      failures++;
      $display("FAIL midreset_async: vo=%b do=%h fc=%0d ri=%b", axis_vo0, axis_do0, frame_cnt, axis_ri0);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    axis_ro0 = 1'b1;
    for (int i = 0; i < 4; i++) send(fill(32'd12), w);
    axis_vi0 = 1'b0;
    checks++;
    if (axis_vo0 !== 1'b1 || axis_do0 !== fill(32'd12) || frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL midreset_frame: vo=%b do=%h fc=%0d want lanes=12 fc=1", axis_vo0, axis_do0, frame_cnt);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_floor();
    test_backpressure();
    test_back_to_back();
    test_clr();
    test_reset_mid();
    axis_ro0 = 1'b1;
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d results never emitted", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cov_accum.md
Name: cov_accum

Overview:
- Sits directly downstream of iq_prod in the DOA receive chain.
- Consumes iq_prod's 512-bit vector: 16 lanes of signed 32-bit I/Q cross-products covering the 4x4 channel covariance terms.
- Integrates 2^LOG2_N consecutive product vectors and emits one averaged covariance snapshot per frame.
- Output is an AXI-Stream-style valid/ready port toward the DOA estimator / DMA.

Parameters:
- LANES, 16, number of product lanes in the input vector.
- DW, 32, signed width of each lane.
- LOG2_N, 10, log2 of the number of vectors averaged per frame (legal range 1..16).

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous frame restart, 1-cycle pulse.
- axis_di0  in  LANES*DW  product vector; lane k = bits [k*DW +: DW], signed.
- axis_vi0  in  1  input valid.
- axis_ri0  out  1  input ready.
- axis_do0  out  LANES*DW  averaged vector, same lane packing.
- axis_vo0  out  1  output valid.
- axis_ro0  in  1  output ready from downstream.
- frame_cnt  out  16  count of frames emitted, wraps at 0xFFFF->0.

Behaviour:
- Reset: axis_vo0=0, axis_do0=0, frame_cnt=0, sample counter=0, all accumulators=0.
  - axis_ri0 is 1 while in reset.
  - Reset mid-frame discards the partial sums and any pending output.
- Input handshake: a sample is taken on any cycle with axis_vi0 && axis_ri0.
- Ready equation: axis_ri0 = !(cnt == 2^LOG2_N-1 && axis_vo0 && !axis_ro0).
  - Input stalls only on the last sample of a frame, and only while the previous result is still unaccepted.
- Accumulators: per lane, signed, width DW+LOG2_N; sign-extend each input lane.
  - Non-last accepted sample: acc += lane, cnt++.
- Last accepted sample (cnt = 2^LOG2_N-1):
  - axis_do0 lane k <= (acc_k + lane_k) >>> LOG2_N, arithmetic shift, floor rounding, truncated to DW. The mean always fits in DW, so no saturation.
  - axis_vo0 <= 1, frame_cnt++, acc <= 0, cnt <= 0.
  - Latency: result valid the cycle after the last-sample handshake.
- Output handshake:
  - axis_do0 and axis_vo0 hold stable while axis_vo0 && !axis_ro0.
  - On axis_vo0 && axis_ro0, axis_vo0 drops next cycle, unless a new frame completes in that same cycle.
  - Simultaneous accept and new-result load: new data loads and axis_vo0 stays 1, giving back-to-back frames with no bubble.
- clr:
  - Zeroes acc and cnt next cycle; a sample presented in the same cycle is discarded.
  - Does not affect axis_vo0, axis_do0 or frame_cnt.
- Frame boundaries: no tlast is consumed; frames are defined purely by the count of accepted samples.
- Stalls: axis_vi0 low freezes acc and cnt indefinitely.

Test Plan (LOG2_N=2 unless noted):
- Four vectors, all lanes 0x00000004, axis_ro0=1 -> one cycle after the 4th handshake, axis_vo0=1, every lane 0x00000004, frame_cnt=1.
- Lane 0 sequence -3,-3,-3,-2; lane 15 sequence 0x7FFFFFFF x4 -> lane 0 = 0xFFFFFFFD (floor of -2.75); lane 15 = 0x7FFFFFFF (no overflow).
- axis_ro0=0 while streaming 8 vectors with axis_vi0=1:
  - frame 1 result holds stable;
  - axis_ri0=0 on the 8th sample;
  - raising axis_ro0 accepts frame 1, then frame 2 appears next cycle;
  - no sample is lost; frame_cnt=2.
- Continuous axis_vi0 and axis_ro0 over 3 frames -> axis_vo0 pulses exactly every 4 cycles; axis_ri0 never drops.
- Two vectors of lanes 100, then clr, then four vectors of lanes 8 -> output lanes 8.
- aresetn low after 2 samples -> outputs return to reset values immediately (asynchronously); the next 4 samples of lanes 12 give lanes 12.
